// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive device.
// Provides register offsets, line status bit indices and the receiver state enum.
package uart_pkg;

    localparam logic [15:0] UART_ADDR = 16'h03f8;
    localparam logic [15:0] LSR_ADDR  = 16'h03fd;

    localparam int unsigned LSR_DR   = 0;
    localparam int unsigned LSR_OE   = 1;
    localparam int unsigned LSR_FE   = 3;
    localparam int unsigned LSR_THRE = 5;
    localparam int unsigned LSR_TEMT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_device_if.sv
// Memory-mapped bus port shared by the UART devices.
// master drives addr/ren/wdata/wen/wstrb and reads rdata; slave is the device side.
interface uart_rx_device_if;
    logic [31:0] addr;
    logic        ren;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  wstrb;

    modport master (output addr, ren, wdata, wen, wstrb, input rdata);
    modport slave  (input addr, ren, wdata, wen, wstrb, output rdata);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pushes when full and pops when empty are ignored.
// Ports: clk, rst_n, push_i/wdata_i write side, pop_i/head_o read side (head_o is
// the current front entry, valid when !empty_o), full_o, empty_o.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    // Read/write pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_rx_device.sv
// Memory-mapped 8N1 UART receiver with receive FIFO and 16550-style line status.
// Ports: clk, rst_n (async active-low), rxd (async serial in, idle high),
// rx_irq (high while FIFO non-empty), bus (slave: RBR at UART_ADDR, LSR at LSR_ADDR).
// Optional macro UART_RX_LOOPBACK_EN: bus writes to UART_ADDR push wdata[7:0] into the FIFO.
module uart_rx_device
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rxd,
    output logic             rx_irq,
    uart_rx_device_if.slave  bus
);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV/2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [1:0]    sync_q;
    logic          rxd_s;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          ser_push, fe_set;
    logic          oe_q, oe_d, fe_q, fe_d, oe_set;
    logic          rx_irq_q;
    logic [31:0]   rdata_q, rdata_d;
    logic [7:0]    lsr;
    logic          data_rd, lsr_rd, pop, push, lb_wr;
    logic [7:0]    push_data, head;
    logic          full, empty;
    logic          unused_bits;

    // Two-flop synchroniser, reset to line idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rxd};
    end
    assign rxd_s = sync_q[1];

    // Receiver state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Receiver next-state: start bit checked mid-bit, then data/stop one bit period apart.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        ser_push = 1'b0;
        fe_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_q == HALF) begin
                    baud_d = '0;
                    bit_d  = '0;
                    state_d = rxd_s ? IDLE : DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            DATA: begin
                if (baud_q == LAST) begin
                    baud_d  = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            STOP: begin
                if (baud_q == LAST) begin
                    baud_d   = '0;
                    state_d  = IDLE;
                    ser_push = rxd_s;
                    fe_set   = ~rxd_s;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef UART_RX_LOOPBACK_EN
    assign lb_wr = bus.wen && (bus.addr[15:0] == UART_ADDR);
`else
    assign lb_wr = 1'b0;
`endif

    // Serial byte has priority over a same-cycle loopback write.
    assign push      = ser_push | lb_wr;
    assign push_data = ser_push ? shift_q : bus.wdata[7:0];
    assign oe_set    = (push & full) | (ser_push & lb_wr);

    assign data_rd = bus.ren && (bus.addr[15:0] == UART_ADDR);
    assign lsr_rd  = bus.ren && (bus.addr[15:0] == LSR_ADDR);
    assign pop     = data_rd & ~empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // Line status and read mux; flags clear on LSR read unless re-set the same cycle.
    always_comb begin
        lsr           = '0;
        lsr[LSR_DR]   = ~empty;
        lsr[LSR_OE]   = oe_q;
        lsr[LSR_FE]   = fe_q;
        lsr[LSR_THRE] = 1'b1;
        lsr[LSR_TEMT] = 1'b1;
        oe_d = (oe_q & ~lsr_rd) | oe_set;
        fe_d = (fe_q & ~lsr_rd) | fe_set;
        if (data_rd)      rdata_d = empty ? 32'd0 : {24'd0, head};
        else if (lsr_rd)  rdata_d = {24'd0, lsr};
        else if (bus.ren) rdata_d = 32'd0;
        else              rdata_d = rdata_q;
    end

    // Flags, read data and interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_q     <= 1'b0;
            fe_q     <= 1'b0;
            rdata_q  <= '0;
            rx_irq_q <= 1'b0;
        end else begin
            oe_q     <= oe_d;
            fe_q     <= fe_d;
            rdata_q  <= rdata_d;
            rx_irq_q <= ~empty;
        end
    end

    assign bus.rdata = rdata_q;
    assign rx_irq    = rx_irq_q;

    assign unused_bits = ^{bus.addr[31:16], bus.wdata[31:8], bus.wen, bus.wstrb};

endmodule

// File: tb/tb_uart_rx_device.sv
// Directed self-checking bench for uart_rx_device (CLK_DIV=16, FIFO_DEPTH=16).
module tb_uart_rx_device;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic rx_irq;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] rd;

    uart_rx_device_if bus ();

    uart_rx_device #(.CLK_DIV(16), .FIFO_DEPTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rxd    (rxd),
        .rx_irq (rx_irq),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.ren  = 1'b1;
        @(posedge clk);
        #1;
        d = bus.rdata;
        @(negedge clk);
        bus.ren = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.addr  = a;
        bus.wdata = v;
        bus.wen   = 1'b1;
        @(negedge clk);
        bus.wen   = 1'b0;
    endtask

    task automatic bit_time(input logic v, input int cycles);
        rxd = v;
        repeat (cycles) @(negedge clk);
    endtask

    // One 8N1 frame; a bad stop bit is held low only long enough to be sampled.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        @(negedge clk);
        bit_time(1'b0, 16);
        for (int i = 0; i < 8; i++) bit_time(b[i], 16);
        if (stop_ok) begin
            bit_time(1'b1, 16);
        end else begin
            bit_time(1'b0, 12);
            bit_time(1'b1, 4);
        end
    endtask

    initial begin
        bus.addr  = '0;
        bus.ren   = 1'b0;
        bus.wdata = '0;
        bus.wen   = 1'b0;
        bus.wstrb = 4'hf;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_rdata", bus.rdata, 32'h0);
        check_eq("reset_irq", 32'(rx_irq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(32'h03fd, rd); check_eq("reset_lsr", rd, 32'h60);
        bus_read(32'h03f8, rd); check_eq("empty_data_rd", rd, 32'h0);

        // Single byte 0x48.
        send_frame(8'h48, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("irq_after_rx", 32'(rx_irq), 32'h1);
        bus_read(32'h03fd, rd); check_eq("lsr_dr", rd, 32'h61);
        bus_read(32'h03f8, rd); check_eq("data_48", rd, 32'h48);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rdata_hold", bus.rdata, 32'h48);
        check_eq("irq_after_pop", 32'(rx_irq), 32'h0);
        bus_read(32'h03fd, rd); check_eq("lsr_empty", rd, 32'h60);
        bus_read(32'h1234_03f9, rd); check_eq("other_addr", rd, 32'h0);

        // Overflow: 17 back-to-back frames into a 16-entry FIFO.
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        repeat (4) @(negedge clk);
        bus_read(32'h03fd, rd); check_eq("lsr_overrun", rd, 32'h63);
        for (int i = 0; i < 16; i++) begin
            bus_read(32'h03f8, rd);
            check_eq($sformatf("ovf_data_%0d", i), rd, 32'(i));
        end
        bus_read(32'h03f8, rd); check_eq("ovf_lost_byte", rd, 32'h0);
        bus_read(32'h03fd, rd); check_eq("lsr_oe_cleared", rd, 32'h60);

        // Framing error.
        send_frame(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("fe_no_irq", 32'(rx_irq), 32'h0);
        bus_read(32'h03fd, rd); check_eq("lsr_fe", rd, 32'h68);
        bus_read(32'h03fd, rd); check_eq("lsr_fe_cleared", rd, 32'h60);

        // Start-bit glitch rejected.
        @(negedge clk);
        bit_time(1'b0, 4);
        bit_time(1'b1, 200);
        check_eq("glitch_state", 32'(dut.state_q), 32'h0);
        bus_read(32'h03fd, rd); check_eq("lsr_glitch", rd, 32'h60);

        // Reset mid-frame, then a clean frame.
        @(negedge clk);
        bit_time(1'b0, 16);
        for (int i = 0; i < 4; i++) bit_time(i[0], 16);
        bit_time(1'b1, 8);
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        bus_read(32'h03f8, rd); check_eq("post_reset_data", rd, 32'hA5);
        bus_read(32'h03fd, rd); check_eq("post_reset_lsr", rd, 32'h60);

`ifdef UART_RX_LOOPBACK_EN
        bus_write(32'h03f8, 32'h0000_006F);
        bus_read(32'h03f8, rd); check_eq("loopback_data", rd, 32'h6F);
        bus_read(32'h03f8, rd); check_eq("loopback_empty", rd, 32'h0);
`else
        bus_write(32'h03f8, 32'h0000_006F);
        bus_read(32'h03fd, rd); check_eq("write_ignored", rd, 32'h60);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_device.md
# uart_rx_device

Memory-mapped UART receive device on the simulation/SoC bus: deserialises 8N1 frames arriving on `rxd`, buffers received bytes in a FIFO and returns them to the CPU on reads of the UART data register. It is the receive end of the write-only UART console at offset 0x03f8, sharing its bus port shape and address decode on `addr[15:0]`. A 16550-style line status register at 0x03fd lets software poll for data and errors.

## Interface
- `CLK_DIV`, 16: clock cycles per serial bit; even, ≥4.
- `FIFO_DEPTH`, 16: receive FIFO entries; power of two, ≥2.
- `UART_ADDR`, 16'h03f8: data register offset (RBR).
- `LSR_ADDR`, 16'h03fd: line status register offset.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `addr`  in  32  byte address; only `addr[15:0]` decoded.
- `ren`  in  1  read strobe, one cycle per read.
- `rdata`  out  32  registered read data.
- `wdata`  in  32  write data (used only with loopback).
- `wen`  in  1  write strobe.
- `wstrb`  in  4  byte strobes; ignored.
- `rxd`  in  1  serial input, idle high, asynchronous to `clk`.
- `rx_irq`  out  1  level high while FIFO non-empty.

## Operation
- `rxd` passes a 2-flop synchroniser (flops reset to 1); FSM uses synchronised `rxd_s`.
- FSM states: IDLE, START, DATA, STOP. Bit counter 3 bits; baud counter `$clog2(CLK_DIV)` bits.
- IDLE: `rxd_s`==0 → START, baud counter cleared.
- START: at count CLK_DIV/2−1 sample; 0 → DATA (counter cleared); 1 → IDLE (glitch rejected, no flag).
- DATA: sample every CLK_DIV cycles, LSB first; after bit 7 → STOP.
- STOP: after CLK_DIV cycles sample; 1 → push byte; 0 → drop byte, set FE. Always → IDLE.
- Push into full FIFO: byte dropped, OE set; FIFO contents unchanged.
- Read `UART_ADDR`: `rdata` = {24'b0, head}, pop; FIFO empty → `rdata`=0, no pop.
- Read `LSR_ADDR`: bit0 DR (non-empty), bit1 OE, bit3 FE, bit5=1, bit6=1, others 0. OE and FE clear on this read.
- Other read addresses → `rdata`=0. Cycles without `ren` → `rdata` holds last value.
- Simultaneous push and pop: both performed, occupancy unchanged; pop on empty with same-cycle push returns 0 and the pushed byte stays.
- Error set and LSR read in same cycle: read returns old value; flag ends set.

## Timing
- Reset: `rdata`=0, `rx_irq`=0, FIFO empty, OE=FE=0, FSM IDLE, synchroniser=1.
- Reset asserted mid-frame: partial byte discarded; after release FSM waits in IDLE for next falling edge.
- Read latency: `rdata` valid the cycle after `ren`; pop takes effect at the same edge.
- Falling `rxd` at edge t → `rxd_s` low at t+2; byte pushed at t+2+CLK_DIV/2+9·CLK_DIV (±1 synchroniser cycle); `rx_irq` high the following cycle.
- Back-to-back frames with no idle gap are received without loss.

## Configuration
- `UART_RX_LOOPBACK_EN` defined: `wen` to `UART_ADDR` pushes `wdata[7:0]` into the FIFO (full → OE). Same-cycle serial push wins; loopback byte dropped and OE set.
- Not defined: all writes ignored; `wdata`/`wen` unused.

## Structure
- Package `uart_pkg`: `UART_ADDR`, `LSR_ADDR`, LSR bit indices (DR, OE, FE, THRE, TEMT), `rx_state_t` enum (IDLE/START/DATA/STOP).
- Sub-module `sync_fifo` (params WIDTH=8, DEPTH): push/pop/full/empty, pointers with extra wrap bit.
- Top holds synchroniser, FSM, flags, read mux.

## Test plan
- Drive 0x48 frame at CLK_DIV=16, read LSR → 0x61; read data → 0x48; LSR → 0x60; `rx_irq` falls after the pop.
- Send 17 bytes 0x00..0x10 with FIFO_DEPTH=16 → LSR=0x63; 16 data reads return 0x00..0x0F; 0x10 lost; next LSR=0x60.
- Frame 0x55 with stop bit 0 → no push, LSR=0x68; second LSR=0x60.
- 4-cycle low glitch on `rxd` → FSM back to IDLE, no push, LSR=0x60.
- Assert `rst_n` at mid-bit 4 of a frame, release, send 0xA5 → only 0xA5 read back.
- With `UART_RX_LOOPBACK_EN`: write 0x6F to 0x03f8 → next data read returns 0x6F; data read on empty FIFO → 0.
